act_lut_loader: RTL and testbench

ACT_LUT_LOADER -- requirements
Module: act_lut_loader

---
 rtl/act_lut_pkg.sv | 14 +
 rtl/act_func_ram.sv | 39 +++
 rtl/act_lut_loader.sv | 114 +++++++++++
 tb/tb_act_lut_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_lut_pkg.sv
// Shared constants and the loader FSM state encoding.
`timescale 1ns/1ps
package act_lut_pkg;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/act_func_ram.sv
// Activation-function storage: one synchronous write port and one
// synchronous read port. The array has no reset, so it maps onto block RAM.
// Only the read output register clears on reset.
`timescale 1ns/1ps
module act_func_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Write port: the entry lands on the same edge that samples we.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: a same-address write on this edge is not yet visible,
  // so the old contents are returned (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/act_lut_loader.sv
// Loads a full activation LUT from a byte stream and serves lookups.
// Byte handshake: a byte is taken on every posedge where rx_rdy=1 while a
// load is in progress. No back-pressure exists. rx_rdy is ignored outside a
// load, and start is ignored while a load or its finish cycle is active.
`timescale 1ns/1ps
module act_lut_loader
  import act_lut_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_rdy,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  lut_vld,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output state_t                fsm_state
);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] count;
  logic                  load_start;
  logic                  accept;
  logic                  last_byte;

  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle strobes.
  always_comb begin
    state_next = state;
    load_start = 1'b0;
    accept     = 1'b0;
    last_byte  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        accept    = rx_rdy;
        last_byte = rx_rdy && (&count);
        if (last_byte) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address counter, running checksum and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      checksum <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      lut_vld  <= 1'b0;
    end else begin
      done <= last_byte;
      if (load_start) begin
        count    <= '0;
        checksum <= '0;
        lut_vld  <= 1'b0;
        busy     <= 1'b1;
      end
      if (accept) begin
        // Wraps to zero after the final entry.
        count    <= count + 1'b1;
        checksum <= checksum + rx_data;
      end
      if (state == FINISH) begin
        busy    <= 1'b0;
        lut_vld <= 1'b1;
      end
    end
  end

  act_func_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (accept),
    .wr_addr (count),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_act_lut_loader.sv
// Bench for act_lut_loader: a phase-level model of the loader checked every
// cycle, plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_act_lut_loader;
  import act_lut_pkg::*;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  // Clock / reset block
  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          start   = 1'b0;
  logic          rx_rdy  = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          lut_vld;
  logic          done;
  logic [DW-1:0] checksum;
  state_t        fsm_state;

  always #5 clk = ~clk;

  act_lut_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .lut_vld   (lut_vld),
    .done      (done),
    .checksum  (checksum),
    .fsm_state (fsm_state)
  );

  int n_cmp     = 0;
  int n_err     = 0;
  int done_seen = 0;
  int busy_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: LUT contents plus load progress
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_live      = 0;
  bit            m_loading   = 0;
  bit            m_finishing = 0;
  bit            m_busy      = 0;
  bit            m_vld       = 0;
  bit            m_done      = 0;
  bit            m_rd_known  = 0;
  int            m_count     = 0;
  logic [DW-1:0] m_sum       = '0;
  logic [DW-1:0] m_rd        = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_live      <= 1;
      m_loading   <= 0;
      m_finishing <= 0;
      m_busy      <= 0;
      m_vld       <= 0;
      m_done      <= 0;
      m_count     <= 0;
      m_sum       <= '0;
      m_rd        <= '0;
      m_rd_known  <= 1;
    end else begin
      m_rd       <= m_mem[rd_addr];
      m_rd_known <= m_known[rd_addr];
      m_done     <= 0;
      if (m_finishing) begin
        m_finishing <= 0;
        m_busy      <= 0;
        m_vld       <= 1;
      end else if (m_loading) begin
        if (rx_rdy) begin
          m_mem[m_count]   <= rx_data;
          m_known[m_count] <= 1;
          m_sum            <= m_sum + rx_data;
          m_count          <= m_count + 1;
          if (m_count == DEPTH - 1) begin
            m_loading   <= 0;
            m_finishing <= 1;
            m_done      <= 1;
          end
        end
      end else if (start) begin
        m_loading <= 1;
        m_count   <= 0;
        m_sum     <= '0;
        m_vld     <= 0;
        m_busy    <= 1;
      end
    end
  end

  // Scoreboard compare: every cycle once reset has been seen
  always @(negedge clk) begin
    if (m_live) begin
      check("busy", busy, m_busy);
      check("lut_vld", lut_vld, m_vld);
      check("done", done, m_done);
      check("checksum", checksum, m_sum);
      if (m_rd_known) check("rd_data", rd_data, m_rd);
      if (done === 1'b1) done_seen++;
    end
  end

  // Driver tasks
  function automatic logic [7:0] byte_for(input int mode, input int i);
    logic [7:0] b;
    case (mode)
      0:       b = i[7:0];
      1:       b = 8'h01;
      2:       b = (i == 0) ? 8'h07 : i[7:0];
      3:       b = (i == 7) ? 8'h33 : 8'h00;
      default: b = (i == 7) ? 8'h55 : 8'(i + 64);
    endcase
    return b;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input int mode, input int duty, input int nbytes,
                          input int restart_at, input bit peek7);
    int gap;
    busy_drop = 0;
    for (int i = 0; i < nbytes; i++) begin
      gap = 0;
      while (duty < 100 && gap < 20 && $urandom_range(0, 99) >= duty) begin
        rx_rdy = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        gap++;
        if (busy !== 1'b1) busy_drop++;
      end
      rx_rdy  = 1'b1;
      rx_data = byte_for(mode, i);
      start   = (i == restart_at);
      if (peek7 && i == 7) rd_addr = 11'd7;
      @(negedge clk);
      if (busy !== 1'b1) busy_drop++;
      if (peek7 && i == 7) check("rbw_old", rd_data, 8'h33);
      if (peek7 && i == 8) check("rbw_new", rd_data, 8'h55);
    end
    rx_rdy = 1'b0;
    start  = 1'b0;
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    int d0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_lut_vld", lut_vld, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;

    // Back-to-back load, byte = address low bits
    pulse_start();
    check("a_busy_on_start", busy, 1);
    d0 = done_seen;
    run_load(0, 100, DEPTH, -1, 0);
    check("a_done_after_last", done, 1);
    @(negedge clk);
    check("a_lut_vld", lut_vld, 1);
    check("a_busy_low", busy, 0);
    check("a_done_clear", done, 0);
    check("a_checksum", checksum, 8'h00);
    check("a_done_once", done_seen - d0, 1);
    rd_addr = 11'h2A5;
    @(negedge clk);
    check("a_rd_2a5", rd_data, 8'hA5);

    // Gapped load of all 0x01
    pulse_start();
    d0 = done_seen;
    run_load(1, 30, DEPTH, -1, 0);
    check("b_busy_held", busy_drop, 0);
    check("b_done_after_last", done, 1);
    @(negedge clk);
    check("b_checksum", checksum, 8'h00);
    check("b_lut_vld", lut_vld, 1);
    check("b_done_once", done_seen - d0, 1);
    rd_addr = 11'd100;
    @(negedge clk);
    check("b_rd_100", rd_data, 8'h01);

    // rx_rdy in IDLE, start during LOAD, rx_rdy in FINISH all ignored
    for (int k = 0; k < 3; k++) begin
      rx_rdy  = 1'b1;
      rx_data = 8'hEE;
      @(negedge clk);
    end
    rx_rdy = 1'b0;
    check("c_idle_rx_ignored", checksum, 8'h00);
    pulse_start();
    d0 = done_seen;
    run_load(2, 100, DEPTH, 500, 0);
    check("c_done_after_last", done, 1);
    rx_rdy  = 1'b1;
    rx_data = 8'h99;
    repeat (3) @(negedge clk);
    rx_rdy = 1'b0;
    check("c_checksum", checksum, 8'h07);
    check("c_lut_vld", lut_vld, 1);
    check("c_done_once", done_seen - d0, 1);
    rd_addr = 11'd0;
    @(negedge clk);
    check("c_rd_0", rd_data, 8'h07);
    rd_addr = 11'd500;
    @(negedge clk);
    check("c_rd_500", rd_data, 8'hF4);

    // Seed address 7 with 0x33, then overwrite it while reading it
    pulse_start();
    run_load(3, 100, DEPTH, -1, 0);
    @(negedge clk);
    check("d_checksum_33", checksum, 8'h33);
    pulse_start();
    run_load(4, 100, 1000, -1, 1);
    check("d_busy_mid", busy, 1);
    check("d_lut_vld_mid", lut_vld, 0);

    // Abandon the load with reset after 1000 bytes
    rd_addr = 11'd10;
    rst     = 1'b1;
    @(negedge clk);
    check("d_rst_busy", busy, 0);
    check("d_rst_lut_vld", lut_vld, 0);
    check("d_rst_checksum", checksum, 0);
    check("d_rst_done", done, 0);
    check("d_rst_rd_data", rd_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("d_rd_10_kept", rd_data, 8'h4A);
    for (int k = 0; k < 5; k++) begin
      rx_rdy  = 1'b1;
      rx_data = 8'h11;
      @(negedge clk);
    end
    rx_rdy = 1'b0;
    @(negedge clk);
    check("d_no_resume_vld", lut_vld, 0);
    check("d_no_resume_busy", busy, 0);
    check("d_no_resume_sum", checksum, 0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
